// File: rtl/ring_router_vc_if.sv
// rtl/ring_router_vc_if.sv - link-side handshake bundle for one ring_router_vc node
// Purpose: groups the three link ports (cw, ccw, pe) of a ring node.
// Per port X: Xdi/Xsi into the node, Xri back to the sender,
// Xdo/Xso out of the node, Xro from the downstream receiver.
// master: the environment side (drives Xdi, Xsi, Xro).
// slave:  the router side (drives Xri, Xdo, Xso).
interface ring_router_vc_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] cwdi, ccwdi, pedi;
  logic              cwsi, ccwsi, pesi;
  logic              cwri, ccwri, peri;
  logic [DATA_W-1:0] cwdo, ccwdo, pedo;
  logic              cwso, ccwso, peso;
  logic              cwro, ccwro, pero;

  modport master (
    output cwdi, ccwdi, pedi, cwsi, ccwsi, pesi, cwro, ccwro, pero,
    input  cwri, ccwri, peri, cwdo, ccwdo, pedo, cwso, ccwso, peso
  );

  modport slave (
    input  cwdi, ccwdi, pedi, cwsi, ccwsi, pesi, cwro, ccwro, pero,
    output cwri, ccwri, peri, cwdo, ccwdo, pedo, cwso, ccwso, peso
  );
endinterface

// File: rtl/ring_router_vc.sv
// rtl/ring_router_vc.sv - bidirectional ring node with two polarity-selected virtual channels
// Purpose: one node of a bidirectional ring with cw, ccw and local pe ports.
// Each port owns a one-entry input and output buffer per VC. The link side
// works on the VC equal to the current polarity; the internal switch works
// on the other VC in the same cycle, so the two never touch the same entry.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-low
//   bus      - ring_router_vc_if.slave, link handshakes for cw/ccw/pe
//   polarity - current cycle polarity (0 = even VC, 1 = odd VC)
module ring_router_vc #(
  parameter int DATA_W  = 64,
  parameter int DIR_BIT = 30,
  parameter int HOP_LSB = 18,
  parameter int HOP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  ring_router_vc_if.slave   bus,
  output logic              polarity
);

  localparam logic [1:0] P_CW  = 2'd0;
  localparam logic [1:0] P_CCW = 2'd1;
  localparam logic [1:0] P_PE  = 2'd2;

  // Contenders per output: index A is the ring input (reset favourite),
  // index B the other input. cw out: cw/pe, ccw out: ccw/pe, pe out: cw/ccw.
  localparam int CONT_A [3] = '{0, 1, 0};
  localparam int CONT_B [3] = '{2, 2, 1};

  logic              pol_q;
  logic              in_v  [3][2];
  logic [DATA_W-1:0] in_d  [3][2];
  logic              out_v [3][2];
  logic [DATA_W-1:0] out_d [3][2];
  // ptr = 0 favours contender A, 1 favours contender B
  logic              ptr   [3][2];

  logic [DATA_W-1:0] link_di [3];
  logic              link_si [3];
  logic              link_ro [3];

  logic p, q;

  assign p        = pol_q;
  assign q        = ~pol_q;
  assign polarity = pol_q;

  assign link_di[0] = bus.cwdi;
  assign link_di[1] = bus.ccwdi;
  assign link_di[2] = bus.pedi;
  assign link_si[0] = bus.cwsi;
  assign link_si[1] = bus.ccwsi;
  assign link_si[2] = bus.pesi;
  assign link_ro[0] = bus.cwro;
  assign link_ro[1] = bus.ccwro;
  assign link_ro[2] = bus.pero;

  assign bus.cwri  = ~in_v[0][p];
  assign bus.ccwri = ~in_v[1][p];
  assign bus.peri  = ~in_v[2][p];
  assign bus.cwso  = out_v[0][p];
  assign bus.ccwso = out_v[1][p];
  assign bus.peso  = out_v[2][p];
  assign bus.cwdo  = out_d[0][p];
  assign bus.ccwdo = out_d[1][p];
  assign bus.pedo  = out_d[2][p];

  // Packets leaving on a ring port consume one hop: shift the hop field right.
  function automatic logic [DATA_W-1:0] hop_shift(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    r[HOP_LSB +: HOP_W] = d[HOP_LSB +: HOP_W] >> 1;
    return r;
  endfunction

  // Route of each input buffer on the switch VC.
  logic [1:0] dst [3];
  logic       req [3];

  always_comb begin
    for (int x = 0; x < 3; x++) begin
      req[x] = in_v[x][q];
    end
    // Ring inputs eject when hop[0] is clear, otherwise continue in the same direction.
    dst[0] = in_d[0][q][HOP_LSB] ? P_CW  : P_PE;
    dst[1] = in_d[1][q][HOP_LSB] ? P_CCW : P_PE;
    // Local injection picks the ring direction from the header bit only.
    dst[2] = in_d[2][q][DIR_BIT] ? P_CCW : P_CW;
  end

  logic              ra [3], rb [3], ga [3], gb [3];
  logic              mv [3];
  logic              take [3];
  logic              ptr_nxt [3];
  logic [DATA_W-1:0] sel_d [3];
  logic [DATA_W-1:0] mv_d [3];

  always_comb begin
    for (int x = 0; x < 3; x++) begin
      take[x] = 1'b0;
    end
    for (int y = 0; y < 3; y++) begin
      ra[y] = req[CONT_A[y]] && (dst[CONT_A[y]] == 2'(y));
      rb[y] = req[CONT_B[y]] && (dst[CONT_B[y]] == 2'(y));
      // A grant needs a free target entry; ties resolved by the pointer.
      ga[y] = ~out_v[y][q] & ra[y] & (~rb[y] | ~ptr[y][q]);
      gb[y] = ~out_v[y][q] & rb[y] & (~ra[y] |  ptr[y][q]);
      mv[y] = ga[y] | gb[y];
      sel_d[y] = ga[y] ? in_d[CONT_A[y]][q] : in_d[CONT_B[y]][q];
      mv_d[y]  = (y == 2) ? sel_d[y] : hop_shift(sel_d[y]);
      // Pointer moves to the loser only when both actually competed.
      ptr_nxt[y] = ptr[y][q];
      if (ra[y] && rb[y] && mv[y]) begin
        ptr_nxt[y] = ga[y];
      end
    end
    for (int y = 0; y < 3; y++) begin
      if (ga[y]) take[CONT_A[y]] = 1'b1;
      if (gb[y]) take[CONT_B[y]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pol_q <= 1'b0;
      for (int x = 0; x < 3; x++) begin
        for (int v = 0; v < 2; v++) begin
          in_v[x][v]  <= 1'b0;
          in_d[x][v]  <= '0;
          out_v[x][v] <= 1'b0;
          out_d[x][v] <= '0;
          ptr[x][v]   <= 1'b0;
        end
      end
    end else begin
      pol_q <= ~pol_q;
      for (int x = 0; x < 3; x++) begin
        // Link side, VC p
        if (link_si[x] && !in_v[x][p]) begin
          in_v[x][p] <= 1'b1;
          in_d[x][p] <= link_di[x];
        end
        if (out_v[x][p] && link_ro[x]) begin
          out_v[x][p] <= 1'b0;
        end
        // Switch side, VC q
        if (take[x]) begin
          in_v[x][q] <= 1'b0;
        end
        if (mv[x]) begin
          out_v[x][q] <= 1'b1;
          out_d[x][q] <= mv_d[x];
          ptr[x][q]   <= ptr_nxt[x];
        end
      end
    end
  end

endmodule
